// File: rtl/adc_acq_window_gen.sv
// Purpose : per-echo ADC acquisition strobe; one ACQ_EN burst per rising edge of ACQ_WND.
// Latency : ACQ_EN first high after edge T0+ADC_INIT_DELAY+1 (T0 = edge that sees the rise), +2 with the synchronizer.
// Backpr. : none; ACQ_WND low during delay or burst aborts, and the burst is re-armed only by a new rising edge.
//
// Ports:
//   CLK              - system clock, all logic on rising edge
//   RESET            - asynchronous active-low reset
//   ADC_INIT_DELAY   - cycles from window start to the first ACQ_EN cycle (latched at T0)
//   SAMPLES_PER_ECHO - ACQ_EN high-time in cycles per window (latched at T0; 0 = no burst)
//   ACQ_WND          - acquisition window level from the sequencer
//   ACQ_EN           - registered ADC acquisition enable
//
// Optional macro ADC_ACQ_WND_SYNC_EN: when defined, ACQ_WND passes through a
// 2-flop synchronizer before edge detection, so it may be asynchronous to CLK.
module adc_acq_window_gen #(
    parameter int unsigned SAMPLES_PER_ECHO_WIDTH = 32,
    parameter int unsigned ADC_INIT_DELAY_WIDTH   = 32
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic [ADC_INIT_DELAY_WIDTH-1:0]   ADC_INIT_DELAY,
    input  logic [SAMPLES_PER_ECHO_WIDTH-1:0] SAMPLES_PER_ECHO,
    input  logic                              ACQ_WND,
    output logic                              ACQ_EN
);

    localparam logic [ADC_INIT_DELAY_WIDTH-1:0]   DLY_ONE = {{(ADC_INIT_DELAY_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SAMPLES_PER_ECHO_WIDTH-1:0] SMP_ONE = {{(SAMPLES_PER_ECHO_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_ACQ   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    logic                              wnd_s;      // window level as seen by the edge detector
    logic                              wnd_q;      // one-cycle history for rising-edge detect
    state_t                            state_q;
    logic [ADC_INIT_DELAY_WIDTH-1:0]   dly_cnt_q;
    logic [SAMPLES_PER_ECHO_WIDTH-1:0] smp_cnt_q;
    logic [SAMPLES_PER_ECHO_WIDTH-1:0] smp_lat_q;  // sample count frozen at window start
    logic                              acq_en_q;
    logic                              start;

`ifdef ADC_ACQ_WND_SYNC_EN
    logic [1:0] wnd_sync_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wnd_sync_q <= 2'b00;
        end else begin
            wnd_sync_q <= {wnd_sync_q[0], ACQ_WND};
        end
    end

    assign wnd_s = wnd_sync_q[1];
`else
    assign wnd_s = ACQ_WND;
`endif

    assign start  = wnd_s & ~wnd_q;
    assign ACQ_EN = acq_en_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wnd_q     <= 1'b0;
            // DONE rather than IDLE: a window already high at reset release
            // must go low before it can start a burst.
            state_q   <= ST_DONE;
            dly_cnt_q <= '0;
            smp_cnt_q <= '0;
            smp_lat_q <= '0;
            acq_en_q  <= 1'b0;
        end else begin
            wnd_q <= wnd_s;
            case (state_q)
                ST_IDLE: begin
                    acq_en_q <= 1'b0;
                    if (start) begin
                        smp_lat_q <= SAMPLES_PER_ECHO;
                        if (SAMPLES_PER_ECHO == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            dly_cnt_q <= ADC_INIT_DELAY;
                            state_q   <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (!wnd_s) begin
                        acq_en_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (dly_cnt_q != '0) begin
                        dly_cnt_q <= dly_cnt_q - DLY_ONE;
                    end else begin
                        smp_cnt_q <= smp_lat_q;
                        acq_en_q  <= 1'b1;
                        state_q   <= ST_ACQ;
                    end
                end
                ST_ACQ: begin
                    if (!wnd_s) begin
                        acq_en_q <= 1'b0;
                        state_q  <= ST_IDLE;
                    end else if (smp_cnt_q == SMP_ONE) begin
                        // The entry edge already produced the first high cycle,
                        // so the burst ends when the count reaches one.
                        smp_cnt_q <= '0;
                        acq_en_q  <= 1'b0;
                        state_q   <= ST_DONE;
                    end else begin
                        smp_cnt_q <= smp_cnt_q - SMP_ONE;
                    end
                end
                ST_DONE: begin
                    acq_en_q <= 1'b0;
                    if (!wnd_s) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    acq_en_q <= 1'b0;
                    state_q  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_acq_window_gen.sv
// Purpose : directed self-checking bench for adc_acq_window_gen (default build, no synchronizer).
// Latency : expectations are cycle indices relative to T0, the edge that first sees ACQ_WND high.
// Backpr. : n/a.
module tb_adc_acq_window_gen;

    logic        CLK;
    logic        RESET;
    logic [31:0] ADC_INIT_DELAY;
    logic [31:0] SAMPLES_PER_ECHO;
    logic        ACQ_WND;
    logic        ACQ_EN;

    int checks;
    int failures;
    int first_i;
    int cnt;
    int last_i;

    adc_acq_window_gen #(
        .SAMPLES_PER_ECHO_WIDTH(32),
        .ADC_INIT_DELAY_WIDTH  (32)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .ADC_INIT_DELAY  (ADC_INIT_DELAY),
        .SAMPLES_PER_ECHO(SAMPLES_PER_ECHO),
        .ACQ_WND         (ACQ_WND),
        .ACQ_EN          (ACQ_EN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Runs one window starting just after a posedge. ACQ_WND is high for edges
    // T0..T0+hi-1 and low for the following lo edges. EN is sampled 1 time
    // unit after each edge; index i means "after edge T0+i".
    // At index chg_at, SAMPLES_PER_ECHO is overwritten with chg_val (-1 = never).
    task automatic run_win(input int d, input int s, input int hi, input int lo,
                           input int chg_at, input int chg_val,
                           output int first, output int n, output int last);
        first = -1;
        n     = 0;
        last  = -1;
        ADC_INIT_DELAY   = d;
        SAMPLES_PER_ECHO = s;
        ACQ_WND          = 1'b1;
        for (int i = 0; i < hi + lo; i++) begin
            @(posedge CLK);
            #1;
            if (ACQ_EN) begin
                n++;
                if (first < 0) first = i;
                last = i;
            end
            if (i == hi - 1) ACQ_WND = 1'b0;
            if (i == chg_at) SAMPLES_PER_ECHO = chg_val;
        end
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        RESET            = 1'b0;
        ACQ_WND          = 1'b0;
        ADC_INIT_DELAY   = 32'd0;
        SAMPLES_PER_ECHO = 32'd4;

        // Reset held while the window toggles: no enable at all.
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            ACQ_WND = ~ACQ_WND;
            check_eq($sformatf("reset_en_%0d", i), int'(ACQ_EN), 0);
        end

        // Release with the window already high: must be ignored.
        ACQ_WND = 1'b1;
        RESET   = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge CLK);
            #1;
            if (ACQ_EN) cnt++;
        end
        check_eq("rel_high_no_burst", cnt, 0);
        ACQ_WND = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Nominal: delay 2, 10 samples -> high after edges T0+3..T0+12.
        run_win(2, 10, 50, 5, -1, 0, first_i, cnt, last_i);
        check_eq("nom_first", first_i, 3);
        check_eq("nom_count", cnt, 10);
        check_eq("nom_last", last_i, 12);

        // Repeat window: identical burst and latency.
        run_win(2, 10, 50, 5, -1, 0, first_i, cnt, last_i);
        check_eq("rep_first", first_i, 3);
        check_eq("rep_count", cnt, 10);
        check_eq("rep_last", last_i, 12);

        // Zero delay: high after edges T0+1..T0+4.
        run_win(0, 4, 20, 3, -1, 0, first_i, cnt, last_i);
        check_eq("zdly_first", first_i, 1);
        check_eq("zdly_count", cnt, 4);
        check_eq("zdly_last", last_i, 4);

        // Zero samples: no pulse.
        run_win(3, 0, 20, 3, -1, 0, first_i, cnt, last_i);
        check_eq("zsmp_count", cnt, 0);

        // Single sample, delay 1: one cycle at T0+2.
        run_win(1, 1, 10, 2, -1, 0, first_i, cnt, last_i);
        check_eq("one_first", first_i, 2);
        check_eq("one_count", cnt, 1);

        // Abort: window high for 6 edges -> high after T0+3..T0+5 only.
        run_win(2, 10, 6, 1, -1, 0, first_i, cnt, last_i);
        check_eq("abort_first", first_i, 3);
        check_eq("abort_count", cnt, 3);
        check_eq("abort_last", last_i, 5);

        // Next window after the abort is a full burst.
        run_win(2, 10, 30, 3, -1, 0, first_i, cnt, last_i);
        check_eq("post_abort_count", cnt, 10);
        check_eq("post_abort_first", first_i, 3);

        // Latching: samples changed to 3 mid-burst; current burst stays 10.
        run_win(2, 10, 30, 3, 5, 3, first_i, cnt, last_i);
        check_eq("latch_cur_count", cnt, 10);
        check_eq("latch_cur_last", last_i, 12);
        run_win(2, 3, 30, 3, -1, 0, first_i, cnt, last_i);
        check_eq("latch_next_count", cnt, 3);
        check_eq("latch_next_last", last_i, 5);

        // Reset mid-burst: enable drops asynchronously, and the still-high
        // window does not restart a burst after release.
        ADC_INIT_DELAY   = 32'd0;
        SAMPLES_PER_ECHO = 32'd10;
        ACQ_WND          = 1'b1;
        repeat (4) @(posedge CLK);
        #1;
        check_eq("midrst_pre_en", int'(ACQ_EN), 1);
        RESET = 1'b0;
        #1;
        check_eq("midrst_async_en", int'(ACQ_EN), 0);
        @(posedge CLK);
        #1;
        RESET = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge CLK);
            #1;
            if (ACQ_EN) cnt++;
        end
        check_eq("midrst_no_restart", cnt, 0);
        ACQ_WND = 1'b0;
        repeat (2) @(posedge CLK);
        #1;

        // Recovery after reset.
        run_win(0, 4, 15, 2, -1, 0, first_i, cnt, last_i);
        check_eq("recov_first", first_i, 1);
        check_eq("recov_count", cnt, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
